// File: rtl/z_core_inst_encoder.sv
// z_core_inst_encoder: RV32I instruction encoder feeding a 2-entry valid/ready output FIFO.
//
// Turns an operation class, an ALU/branch op code, register indices and an immediate
// into a 32-bit RV32I word. Illegal requests encode as the NOP 0x00000013.
//
// Build option: define Z_CORE_ENC_CHECK_EN to enable immediate range checks and the
// out_err flag. Without it, immediates are truncated to their fields and out_err is 0.
//
// Ports:
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  request handshake; in_ready depends on FIFO occupancy only
//   in_kind            0 R, 1 I, 2 LW, 3 SW, 4 BRANCH, 5 JAL, 6 LUI, 7 AUIPC
//   in_inst_type       ALU op 0..9 or branch op 10..15
//   in_rd/rs1/rs2      register indices
//   in_imm             sign-extended immediate (full value for LUI/AUIPC)
//   out_valid/ready    FIFO head handshake
//   out_inst, out_err  head word and its illegal flag
module z_core_inst_encoder #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_kind,
    input  logic [3:0]  in_inst_type,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err
);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [2:0]  w_f3_alu;
    logic [2:0]  w_f3_br;
    logic [6:0]  w_f7;
    logic        w_shift;
    logic        w_ge10;
    logic [31:0] w_enc;
    logic        w_bad_combo;
    logic        w_illegal;
    logic        w_err;
    logic [31:0] w_word;
    logic        w_push;
    logic        w_pop;
    logic        w_unused;

    logic [31:0] r_mem_inst [2];
    logic        r_mem_err  [2];
    logic        r_wp;
    logic        r_rp;
    logic [1:0]  r_count;

    assign w_unused = in_imm[0];

    always_comb begin
        w_f3_alu = 3'b000;
        case (in_inst_type)
            4'd2:       w_f3_alu = 3'b001;
            4'd3:       w_f3_alu = 3'b010;
            4'd4:       w_f3_alu = 3'b011;
            4'd5:       w_f3_alu = 3'b100;
            4'd6, 4'd7: w_f3_alu = 3'b101;
            4'd8:       w_f3_alu = 3'b110;
            4'd9:       w_f3_alu = 3'b111;
            default:    w_f3_alu = 3'b000;
        endcase
    end

    // Branch codes 10..15 (1010..1111) map onto funct3 000,001,100,101,110,111 bitwise.
    assign w_f3_br = {in_inst_type[2], in_inst_type[2] & in_inst_type[1], in_inst_type[0]};
    assign w_f7    = (in_inst_type == 4'd1 || in_inst_type == 4'd7) ? 7'b0100000 : 7'b0000000;
    assign w_shift = (in_inst_type == 4'd2 || in_inst_type == 4'd6 || in_inst_type == 4'd7);
    assign w_ge10  = (in_inst_type >= 4'd10);

    always_comb begin
        w_enc       = NOP;
        w_bad_combo = 1'b0;
        case (in_kind)
            3'd0: begin
                w_enc       = {w_f7, in_rs2, in_rs1, w_f3_alu, in_rd, OP_R};
                w_bad_combo = w_ge10;
            end
            3'd1: begin
                w_enc       = w_shift ? {w_f7, in_imm[4:0], in_rs1, w_f3_alu, in_rd, OP_I}
                                      : {in_imm[11:0], in_rs1, w_f3_alu, in_rd, OP_I};
                w_bad_combo = w_ge10 || in_inst_type == 4'd1;
            end
            3'd2: w_enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LOAD};
            3'd3: w_enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_STORE};
            3'd4: begin
                w_enc       = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, w_f3_br,
                               in_imm[4:1], in_imm[11], OP_BRANCH};
                w_bad_combo = !w_ge10;
            end
            3'd5: w_enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
            3'd6: w_enc = {in_imm[31:12], in_rd, OP_LUI};
            default: w_enc = {in_imm[31:12], in_rd, OP_AUIPC};
        endcase
    end

`ifdef Z_CORE_ENC_CHECK_EN
    logic w_s12;
    logic w_s13;
    logic w_s21;
    logic w_bad_range;

    // An immediate fits in N signed bits when bits [31:N-1] are all equal.
    assign w_s12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign w_s13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign w_s21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    always_comb begin
        w_bad_range = 1'b0;
        case (in_kind)
            3'd0:       w_bad_range = 1'b0;
            3'd1:       w_bad_range = w_shift ? (|in_imm[31:5]) : !w_s12;
            3'd2, 3'd3: w_bad_range = !w_s12;
            3'd4:       w_bad_range = !w_s13 || in_imm[0];
            3'd5:       w_bad_range = !w_s21 || in_imm[0];
            default:    w_bad_range = |in_imm[11:0];
        endcase
    end

    assign w_illegal = w_bad_combo | w_bad_range;
    assign w_err     = w_illegal;
`else
    assign w_illegal = w_bad_combo;
    assign w_err     = 1'b0;
`endif

    assign w_word    = w_illegal ? NOP : w_enc;
    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // When empty, the slot behind the read pointer is the last word popped (or the reset
    // value), and a push into an empty FIFO writes at the read pointer, so it stays intact.
    assign out_inst = r_mem_inst[out_valid ? r_rp : ~r_rp];
    assign out_err  = r_mem_err[out_valid ? r_rp : ~r_rp];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mem_inst[0] <= '0;
            r_mem_inst[1] <= '0;
            r_mem_err[0]  <= 1'b0;
            r_mem_err[1]  <= 1'b0;
            r_wp          <= 1'b0;
            r_rp          <= 1'b0;
            r_count       <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem_inst[r_wp] <= w_word;
                r_mem_err[r_wp]  <= w_err;
                r_wp             <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
endmodule

// File: doc/z_core_inst_encoder.md
# z_core_inst_encoder

RV32I instruction encoder: the reverse of the core's ALU-control decode. It accepts an operation class, an ALU/branch operation code (same 4-bit `alu_inst_type` numbering the core decodes to), register indices and an immediate, and emits the 32-bit instruction word. Encoded words pass through a 2-entry output FIFO with valid/ready handshakes on both sides. It sits in the self-test/boot path, feeding generated programs into instruction memory or straight into the fetch stage.

## Interface
- `FIFO_DEPTH`, 2: output FIFO entries; only 2 is supported.
- `clk` input 1: clock, rising edge.
- `rstn` input 1: reset. One clock; reset is asynchronous and active-low.
- `in_valid` input 1: request valid.
- `in_ready` output 1: request accepted on a cycle where `in_valid & in_ready`.
- `in_kind` input 3: 0 R-ALU, 1 I-ALU, 2 LOAD (LW), 3 STORE (SW), 4 BRANCH, 5 JAL, 6 LUI, 7 AUIPC.
- `in_inst_type` input 4: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU. Ignored for kinds 2, 3, 5, 6, 7.
- `in_rd`, `in_rs1`, `in_rs2` input 5 each: register indices. Fields a format does not use are ignored.
- `in_imm` input 32: byte immediate, sign-extended value. For LUI/AUIPC, the full 32-bit value.
- `out_valid` output 1: FIFO head valid.
- `out_ready` input 1: consumer accepts the head.
- `out_inst` output 32: encoded word at the FIFO head.
- `out_err` output 1: head entry was illegal. `out_inst` then holds the NOP 0x00000013.

## Operation
- Opcodes:
  - R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
  - JAL 1101111, LUI 0110111, AUIPC 0010111.
- funct3:
  - ALU: ADD/SUB 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111.
  - Branch: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
  - LW/SW: 010.
- funct7: 0100000 for SUB and SRA/SRAI, otherwise 0000000.
- Formats:
  - I: imm[11:0] at [31:20].
  - SLLI/SRLI/SRAI: funct7 at [31:25], shamt imm[4:0] at [24:20].
  - S: imm[11:5] at [31:25], imm[4:0] at [11:7].
  - B: imm[12|10:5] at [31:25], imm[4:1|11] at [11:7].
  - J: imm[20|10:1|11|19:12] at [31:12].
  - U: imm[31:12] at [31:12].
- Illegal combinations are always detected and produce the NOP. The `out_err` flag depends on the Configuration section.
  - R with type ≥10.
  - I with type SUB or ≥10.
  - BRANCH with type <10.
- Range checks (only in the checked build):
  - I/LOAD/STORE: imm must be signed 12-bit.
  - Shifts: imm[31:5] must be 0.
  - BRANCH: imm must be signed 13-bit and imm[0]=0.
  - JAL: imm must be signed 21-bit and imm[0]=0.
  - LUI/AUIPC: imm[11:0] must be 0.
- FIFO:
  - Encoding is combinational on the inputs. The word and error flag are written into the FIFO on acceptance.
  - `count` runs 0..2. `in_ready = (count != 2)` and is registered-state only, with no combinational path from `out_ready`.
  - Push and pop in the same cycle leaves `count` unchanged. Order is strictly preserved.

## Timing
- Reset values: `out_valid` 0, `out_inst` 0x00000000, `out_err` 0, `in_ready` 1, count 0, pointers 0.
- Latency: a request accepted at edge N appears at the head with `out_valid`=1 after edge N (visible in cycle N+1) if the FIFO was empty.
- Throughput is 1 word/cycle while `out_ready`=1.
- Full (count 2): `in_ready`=0. A pop at edge N raises `in_ready` in cycle N+1.
- Empty: `out_valid`=0. `out_inst`/`out_err` are held at their last values, or 0 after reset.
- `out_inst`/`out_err` stay stable while `out_valid & !out_ready`.
- Pointers are 1 bit and wrap modulo 2.
- Reset asserted mid-operation: FIFO contents are discarded immediately, and outputs return to their reset values asynchronously.

## Configuration
- `Z_CORE_ENC_CHECK_EN` defined: range checks active. Any illegal request produces NOP with `out_err`=1.
- `Z_CORE_ENC_CHECK_EN` undefined: no range checks, and immediates are truncated to the field bits. Illegal kind/type combinations still produce NOP. `out_err` is constant 0.

## Test plan
- R ADD, rd=3, rs1=1, rs2=2; then SUB with the same registers → 0x002081B3, then 0x402081B3, each one cycle after acceptance.
- I SRAI, rd=5, rs1=6, imm=3 → 0x40335293. LUI, rd=1, imm=0x12345000 → 0x123450B7.
- BRANCH BEQ, rs1=1, rs2=2, imm=0xFFFFFFFC → 0xFE208EE3.
- Checked build: I ADD with imm=2048 → `out_err`=1, `out_inst`=0x00000013. Unchecked build: `out_err`=0.
- Backpressure: `out_ready`=0, then offer 3 requests → two accepted and `in_ready`=0. Raise `out_ready` → words emerge in order, third accepted the cycle after the first pop.
- `rstn` pulsed low with 2 entries queued → `out_valid`=0 and `in_ready`=1 immediately. No stale word appears after release.
